// File: rtl/ddr4_cmd_sequencer.sv
// DDR4 command sequencer: power-up/MRS/ZQ initialisation, then single-page RD/WR service
// with periodic refresh. All DRAM timing is enforced by saturating down-counters.
module ddr4_cmd_sequencer #(
  parameter int          T_RESET = 16,
  parameter int          T_CKE   = 8,
  parameter int          T_XPR   = 12,
  parameter int          T_MRD   = 8,
  parameter int          T_MOD   = 24,
  parameter int          T_ZQ    = 512,
  parameter int          T_RCD   = 9,
  parameter int          T_RP    = 9,
  parameter int          T_RAS   = 28,
  parameter int          T_RTP   = 6,
  parameter int          T_WR    = 12,
  parameter int          T_WTR   = 3,
  parameter int          T_CCD   = 4,
  parameter int          T_REFI  = 6240,
  parameter int          T_RFC   = 208,
  parameter logic [97:0] MR_INIT = '0
) (
  input  logic        CK_t,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [16:0] req_row,
  input  logic [9:0]  req_col,
  output logic        init_done,
  output logic        reset_n,
  output logic        CKE,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic [13:0] A
);

  typedef logic [15:0] cnt_t;

  // Refresh is requested this many cycles early so the worst-case PRE/tRP drain
  // still lands the REF inside tREFI+4 of the previous one.
  localparam int   REF_LEAD   = 64;
  localparam cnt_t L_RESET    = cnt_t'(T_RESET - 1);
  localparam cnt_t L_CKE      = cnt_t'(T_CKE - 1);
  localparam cnt_t L_XPR      = cnt_t'(T_XPR - 1);
  localparam cnt_t L_MRD      = cnt_t'(T_MRD - 1);
  localparam cnt_t L_MOD      = cnt_t'(T_MOD - 1);
  localparam cnt_t L_ZQ       = cnt_t'(T_ZQ - 1);
  localparam cnt_t L_RCD      = cnt_t'(T_RCD - 1);
  localparam cnt_t L_RP       = cnt_t'(T_RP - 1);
  localparam cnt_t L_RAS      = cnt_t'(T_RAS - 1);
  localparam cnt_t L_RTP      = cnt_t'(T_RTP - 1);
  localparam cnt_t L_WR2PRE   = cnt_t'(T_WTR + 4 + T_WR - 1);
  localparam cnt_t L_WR2RD    = cnt_t'(T_WTR + 4 - 1);
  localparam cnt_t L_RD2WR    = cnt_t'(T_CCD + T_WTR + 4 - 1);
  localparam cnt_t L_CCD      = cnt_t'(T_CCD - 1);
  localparam cnt_t L_RFC      = cnt_t'(T_RFC - 1);
  localparam cnt_t L_REFI     = cnt_t'(T_REFI - REF_LEAD - 1);

  typedef enum logic [3:0] {
    S_RST, S_CKE, S_XPR, S_MRS, S_MOD, S_ZQ, S_IDLE, S_ACT, S_CAS, S_PRE, S_REF
  } state_t;

  typedef enum logic [2:0] {C_DES, C_ACT, C_MRS, C_PRE, C_REF, C_RD, C_WR, C_ZQ} cmd_t;

  function automatic cnt_t dec(input cnt_t c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  function automatic cnt_t cmax(input cnt_t a, input cnt_t b);
    return (a > b) ? a : b;
  endfunction

  // MRS issue order is MR3, MR6, MR5, MR4, MR2, MR1, MR0.
  function automatic logic [2:0] mr_num(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd3;
      3'd1:    return 3'd6;
      3'd2:    return 3'd5;
      3'd3:    return 3'd4;
      3'd4:    return 3'd2;
      3'd5:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  state_t      state, state_nxt;
  cmd_t        cmd;
  cnt_t        init_cnt, init_cnt_nxt;
  logic [2:0]  mrs_idx, mrs_idx_nxt, mr;
  cnt_t        rp_cnt, rfc_cnt, pre_cnt, rd_ok, wr_ok, ref_cnt;
  logic        cap_wr, page_vld;
  logic [1:0]  cap_bg, cap_ba, page_bg, page_ba;
  logic [16:0] cap_row, page_row;
  logic [9:0]  cap_col;
  logic        take_req, rstn_set, cke_set, done_set, ref_pend, hit;
  logic [4:0]  bus_nxt;
  logic [1:0]  bg_nxt, ba_nxt;
  logic [13:0] a_nxt;

  assign ref_pend = init_done && (ref_cnt == '0);
  assign hit      = page_vld && (page_bg == req_bg) && (page_ba == req_ba) && (page_row == req_row);
  assign mr       = mr_num(mrs_idx);

  always_comb begin
    state_nxt    = state;
    cmd          = C_DES;
    take_req     = 1'b0;
    rstn_set     = 1'b0;
    cke_set      = 1'b0;
    done_set     = 1'b0;
    init_cnt_nxt = dec(init_cnt);
    mrs_idx_nxt  = mrs_idx;
    case (state)
      S_RST: if (init_cnt == '0) begin
        rstn_set = 1'b1; init_cnt_nxt = L_CKE; state_nxt = S_CKE;
      end
      S_CKE: if (init_cnt == '0) begin
        cke_set = 1'b1; init_cnt_nxt = L_XPR; state_nxt = S_XPR;
      end
      S_XPR: if (init_cnt == '0) begin
        cmd = C_MRS; mrs_idx_nxt = 3'd1; init_cnt_nxt = L_MRD; state_nxt = S_MRS;
      end
      S_MRS: if (init_cnt == '0) begin
        cmd = C_MRS;
        if (mrs_idx == 3'd6) begin
          init_cnt_nxt = L_MOD; state_nxt = S_MOD;
        end else begin
          mrs_idx_nxt = mrs_idx + 3'd1; init_cnt_nxt = L_MRD;
        end
      end
      S_MOD: if (init_cnt == '0) begin
        cmd = C_ZQ; init_cnt_nxt = L_ZQ; state_nxt = S_ZQ;
      end
      S_ZQ: if (init_cnt == '0) begin
        done_set = 1'b1; state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (ref_pend) begin
          state_nxt = page_vld ? S_PRE : S_REF;
        end else if (req_valid) begin
          take_req  = 1'b1;
          state_nxt = hit ? S_CAS : (page_vld ? S_PRE : S_ACT);
        end
      end
      S_PRE: if (pre_cnt == '0 && rfc_cnt == '0) begin
        cmd = C_PRE; state_nxt = ref_pend ? S_REF : S_ACT;
      end
      S_REF: if (rp_cnt == '0 && rfc_cnt == '0) begin
        cmd = C_REF; state_nxt = S_IDLE;
      end
      S_ACT: if (rp_cnt == '0 && rfc_cnt == '0) begin
        cmd = C_ACT; state_nxt = S_CAS;
      end
      S_CAS: if ((cap_wr ? wr_ok : rd_ok) == '0 && rfc_cnt == '0) begin
        cmd = cap_wr ? C_WR : C_RD; state_nxt = S_IDLE;
      end
      default: state_nxt = S_RST;
    endcase

    bus_nxt = 5'b11111;
    bg_nxt  = '0;
    ba_nxt  = '0;
    a_nxt   = '0;
    case (cmd)
      C_ACT: begin bus_nxt = {2'b00, cap_row[16:14]}; bg_nxt = cap_bg; ba_nxt = cap_ba; a_nxt = cap_row[13:0]; end
      C_MRS: begin bus_nxt = 5'b01000; bg_nxt = {1'b0, mr[2]}; ba_nxt = mr[1:0]; a_nxt = MR_INIT[int'(mr)*14 +: 14]; end
      C_PRE: begin bus_nxt = 5'b01010; bg_nxt = page_bg; ba_nxt = page_ba; end
      C_REF: bus_nxt = 5'b01001;
      C_RD:  begin bus_nxt = 5'b01101; bg_nxt = cap_bg; ba_nxt = cap_ba; a_nxt = {4'b0, cap_col}; end
      C_WR:  begin bus_nxt = 5'b01100; bg_nxt = cap_bg; ba_nxt = cap_ba; a_nxt = {4'b0, cap_col}; end
      C_ZQ:  begin bus_nxt = 5'b01110; a_nxt[10] = 1'b1; end
      default: bus_nxt = 5'b11111;
    endcase
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      state     <= S_RST;
      init_cnt  <= L_RESET;
      mrs_idx   <= '0;
      rp_cnt    <= '0;
      rfc_cnt   <= '0;
      pre_cnt   <= '0;
      rd_ok     <= '0;
      wr_ok     <= '0;
      ref_cnt   <= '0;
      cap_wr    <= 1'b0;
      cap_bg    <= '0;
      cap_ba    <= '0;
      cap_row   <= '0;
      cap_col   <= '0;
      page_vld  <= 1'b0;
      page_bg   <= '0;
      page_ba   <= '0;
      page_row  <= '0;
      init_done <= 1'b0;
      reset_n   <= 1'b0;
      CKE       <= 1'b0;
      req_ready <= 1'b0;
      {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= 5'b11111;
      bg_addr   <= '0;
      ba_addr   <= '0;
      A         <= '0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      mrs_idx   <= mrs_idx_nxt;
      rp_cnt    <= (cmd == C_PRE) ? L_RP  : dec(rp_cnt);
      rfc_cnt   <= (cmd == C_REF) ? L_RFC : dec(rfc_cnt);
      ref_cnt   <= (done_set || cmd == C_REF) ? L_REFI : dec(ref_cnt);
      case (cmd)
        C_ACT: begin
          pre_cnt <= cmax(dec(pre_cnt), L_RAS);
          rd_ok   <= cmax(dec(rd_ok), L_RCD);
          wr_ok   <= cmax(dec(wr_ok), L_RCD);
        end
        C_RD: begin
          pre_cnt <= cmax(dec(pre_cnt), L_RTP);
          rd_ok   <= cmax(dec(rd_ok), L_CCD);
          wr_ok   <= cmax(dec(wr_ok), L_RD2WR);
        end
        C_WR: begin
          pre_cnt <= cmax(dec(pre_cnt), L_WR2PRE);
          rd_ok   <= cmax(dec(rd_ok), L_WR2RD);
          wr_ok   <= cmax(dec(wr_ok), L_CCD);
        end
        default: begin
          pre_cnt <= dec(pre_cnt);
          rd_ok   <= dec(rd_ok);
          wr_ok   <= dec(wr_ok);
        end
      endcase
      if (take_req) begin
        cap_wr  <= req_wr;
        cap_bg  <= req_bg;
        cap_ba  <= req_ba;
        cap_row <= req_row;
        cap_col <= req_col;
      end
      if (cmd == C_ACT) begin
        page_vld <= 1'b1;
        page_bg  <= cap_bg;
        page_ba  <= cap_ba;
        page_row <= cap_row;
      end else if (cmd == C_PRE || cmd == C_REF) begin
        page_vld <= 1'b0;
      end
      init_done <= init_done | done_set;
      reset_n   <= reset_n | rstn_set;
      CKE       <= CKE | cke_set;
      req_ready <= (cmd == C_RD) || (cmd == C_WR);
      {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= bus_nxt;
      bg_addr   <= bg_nxt;
      ba_addr   <= ba_nxt;
      A         <= a_nxt;
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed bench for ddr4_cmd_sequencer: init timing, page hit/empty/miss, turnarounds,
// refresh with an open page, and reset during a tRCD wait.
module tb_ddr4_cmd_sequencer;

  localparam logic [4:0] DES = 5'b11111;
  localparam logic [4:0] MRS = 5'b01000;
  localparam logic [4:0] PRE = 5'b01010;
  localparam logic [4:0] REF = 5'b01001;
  localparam logic [4:0] RD  = 5'b01101;
  localparam logic [4:0] WR  = 5'b01100;
  localparam logic [4:0] ZQC = 5'b01110;
  localparam logic [4:0] ACT = 5'b00000;

  logic        CK_t = 1'b0;
  logic        reset, req_valid, req_wr;
  logic [1:0]  req_bg, req_ba;
  logic [16:0] req_row;
  logic [9:0]  req_col;
  logic        req_ready, init_done, reset_n, CKE;
  logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0]  bg_addr, ba_addr;
  logic [13:0] A;
  logic [4:0]  bus;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  assign bus = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14};

  ddr4_cmd_sequencer dut (
    .CK_t(CK_t), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .init_done(init_done), .reset_n(reset_n), .CKE(CKE), .cs_n(cs_n), .act_n(act_n),
    .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .A(A)
  );

  always #5 CK_t = ~CK_t;
  always @(posedge CK_t) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for the next non-DES command; t=-1 on timeout.
  task automatic next_cmd(input int bound, output int t, output logic [4:0] c);
    t = -1;
    c = DES;
    for (int i = 0; i < bound; i++) begin
      @(negedge CK_t);
      if (bus != DES) begin
        t = cyc;
        c = bus;
        break;
      end
    end
  endtask

  task automatic wait_pin(input int bound, input bit want_cke, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge CK_t);
      if ((want_cke ? CKE : reset_n) === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pins"}, int'({reset_n, CKE, req_ready, init_done}), 0);
    check({tag, "_bus"}, int'({bus, bg_addr, ba_addr, A}), int'({5'b11111, 18'b0}));
  endtask

  initial begin
    int t, tp, t_act, t_wr, t_rel, cnt;
    logic [4:0] c;
    logic [2:0] mr_order [7];
    mr_order = '{3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
    req_bg = '0; req_ba = '0; req_row = '0; req_col = '0;
    repeat (3) @(negedge CK_t);
    check_reset_outputs("reset0");

    // Initialisation sequence
    reset = 1'b0; t_rel = cyc;
    wait_pin(40, 1'b0, t);  check("rstn_rise", t - t_rel, 16);
    tp = t;
    wait_pin(20, 1'b1, t);  check("cke_rise", t - tp, 8);
    tp = t;
    for (int k = 0; k < 7; k++) begin
      next_cmd(20, t, c);
      check("mrs_code", int'(c), int'(MRS));
      check("mrs_gap", t - tp, (k == 0) ? 12 : 8);
      check("mrs_num", int'({bg_addr[0], ba_addr}), int'(mr_order[k]));
      tp = t;
    end
    next_cmd(40, t, c);
    check("zqcl_code", int'(c), int'(ZQC));
    check("zqcl_gap", t - tp, 24);
    tp = t;
    t = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge CK_t);
      if (init_done) begin t = cyc; break; end
    end
    check("init_done_gap", t - tp, 512);

    // Two reads to an empty page, same row
    req_valid = 1'b1; req_wr = 1'b0; req_bg = 2'd1; req_ba = 2'd2; req_row = 17'd5; req_col = 10'h010;
    next_cmd(20, t_act, c);
    check("act_code", int'(c), int'(ACT));
    check("act_addr", int'({bg_addr, ba_addr, A}), int'({2'd1, 2'd2, 14'd5}));
    next_cmd(20, t, c);
    check("rd1_code", int'(c), int'(RD));
    check("rd1_trcd", t - t_act, 9);
    check("rd1_ready", int'(req_ready), 1);
    check("rd1_col", int'(A), 'h010);
    tp = t; req_col = 10'h020;
    next_cmd(20, t, c);
    check("rd2_code", int'(c), int'(RD));
    check("rd2_tccd", t - tp, 4);
    check("rd2_ready", int'(req_ready), 1);

    // RD -> WR and WR -> RD turnarounds on the open page
    tp = t; req_wr = 1'b1; req_col = 10'h030;
    next_cmd(30, t, c);
    check("wr_code", int'(c), int'(WR));
    check("rd_to_wr", t - tp, 11);
    check("wr_ready", int'(req_ready), 1);
    t_wr = t; req_wr = 1'b0; req_col = 10'h040;
    next_cmd(30, t, c);
    check("rd3_code", int'(c), int'(RD));
    check("wr_to_rd", t - t_wr, 7);

    // Page miss: row 5 -> row 6 (write-recovery bound), then row 6 -> row 7 (tRAS bound)
    req_row = 17'd6;
    next_cmd(40, t, c);
    check("pre1_code", int'(c), int'(PRE));
    check("pre1_twr", t - t_wr, 19);
    check("pre1_tras_ok", int'(t - t_act >= 28), 1);
    check("pre1_addr", int'({bg_addr, ba_addr, A[10]}), int'({2'd1, 2'd2, 1'b0}));
    tp = t;
    next_cmd(20, t_act, c);
    check("act2_code", int'(c), int'(ACT));
    check("act2_trp", t_act - tp, 9);
    check("act2_row", int'(A), 6);
    next_cmd(20, t, c);
    check("rd4_trcd", t - t_act, 9);
    check("rd4_ready", int'(req_ready), 1);
    req_row = 17'd7;
    next_cmd(40, t, c);
    check("pre2_code", int'(c), int'(PRE));
    check("pre2_tras", t - t_act, 28);
    tp = t;
    next_cmd(20, t_act, c);
    check("act3_trp", t_act - tp, 9);
    check("act3_row", int'(A), 7);
    next_cmd(20, t, c);
    check("rd5_code", int'(c), int'(RD));
    check("rd5_trcd", t - t_act, 9);
    req_valid = 1'b0;

    // Refresh with a page open, then a pending request gets a fresh ACT
    next_cmd(7000, tp, c);
    check("ref_pre_code", int'(c), int'(PRE));
    req_valid = 1'b1; req_row = 17'd7; req_col = 10'h055;
    next_cmd(20, t, c);
    check("ref_code", int'(c), int'(REF));
    check("ref_trp", t - tp, 9);
    tp = t;
    next_cmd(300, t_act, c);
    check("post_ref_act", int'(c), int'(ACT));
    check("post_ref_trfc", int'((t_act - tp >= 208) && (t_act - tp <= 212)), 1);
    check("post_ref_row", int'(A), 7);
    next_cmd(20, t, c);
    check("post_ref_rd", int'({c, req_ready}), int'({RD, 1'b1}));
    check("post_ref_trcd", t - t_act, 9);

    // Reset during a tRCD wait
    req_row = 17'd8;
    next_cmd(40, t, c);
    check("rst_pre_code", int'(c), int'(PRE));
    next_cmd(20, t, c);
    check("rst_act_code", int'(c), int'(ACT));
    repeat (3) @(negedge CK_t);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CK_t);
      if (cs_n !== 1'b1 || req_ready !== 1'b0) cnt++;
    end
    check("no_cmd_in_reset", cnt, 0);
    reset = 1'b0; t_rel = cyc;
    wait_pin(40, 1'b0, t);  check("replay_rstn", t - t_rel, 16);
    tp = t;
    wait_pin(20, 1'b1, t);  check("replay_cke", t - tp, 8);
    tp = t;
    next_cmd(20, t, c);
    check("replay_mrs3", int'({c, bg_addr[0], ba_addr}), int'({MRS, 3'd3}));
    check("replay_xpr", t - tp, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
